// File: rtl/timer_dev.sv
// Memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes.
// Raises IRQ when the count expires.
module timer_dev (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic        irq_q, irq_d;

  logic ctrl_we, preset_we, en, auto_reload;
  logic unused_din_hi;

  assign ctrl_we       = We && (Addr == 2'd0);
  assign preset_we     = We && (Addr == 2'd1);
  assign en            = ctrl_q[0];
  assign auto_reload   = (ctrl_q[2:1] == 2'b01);
  assign unused_din_hi = ^DIn[31:4];

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;

    if (preset_we) preset_d = DIn;
    if (ctrl_we) begin
      ctrl_d = DIn[3:0];
      pend_d = 1'b0;
    end

    case (state_q)
      IDLE: if (en) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // A preset of 0 lands here too, so the count never wraps.
          count_d = 32'd0;
          state_d = INT;
          pend_d  = 1'b1;
        end
      end
      INT: begin
        if (auto_reload) begin
          state_d = LOAD;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
          if (!ctrl_we) ctrl_d[0] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // IRQ is a flop of its own so it cannot glitch on decode.
    irq_d = pend_d & ctrl_d[3];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    case (Addr)
      2'd0:    DOut = {28'd0, ctrl_q};
      2'd1:    DOut = preset_q;
      2'd2:    DOut = count_q;
      default: DOut = 32'd0;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: one-shot, auto-reload, zero preset, masking,
// pause/restart with preset change, and asynchronous reset.
`timescale 1ns/1ps
module tb_timer_dev;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  Addr = 2'd0;
  logic        We = 1'b0;
  logic [31:0] DIn = 32'd0;
  logic [31:0] DOut;
  logic        IRQ;

  int total = 0;
  int bad = 0;

  timer_dev dut (
    .clk(clk), .rst(rst), .Addr(Addr), .We(We), .DIn(DIn), .DOut(DOut), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    Addr = a;
    #0.1;
    chk(tag, DOut, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'd0, IRQ}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    We = 1'b1; Addr = a; DIn = d;
    @(posedge clk);
    #1;
    We = 1'b0;
    $display("write addr=%0d data=%0h", a, d);
  endtask

  // Asserts rst in the low phase and checks outputs before any rising edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #1 rst = 1'b1;
    #0.1 chk_irq({tag, "_irq"}, 1'b0);
    chk_rd({tag, "_ctrl"}, 2'd0, 32'd0);
    chk_rd({tag, "_preset"}, 2'd1, 32'd0);
    chk_rd({tag, "_count"}, 2'd2, 32'd0);
    chk_rd({tag, "_rsvd"}, 2'd3, 32'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk_irq("rst_irq", 1'b0);
    chk_rd("rst_ctrl", 2'd0, 32'd0);
    chk_rd("rst_preset", 2'd1, 32'd0);
    chk_rd("rst_count", 2'd2, 32'd0);
    chk_rd("rst_rsvd", 2'd3, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // One-shot, PRESET=5, IM=1
    wr(2'd1, 32'd5);
    chk_rd("preset5", 2'd1, 32'd5);
    wr(2'd0, 32'h9);
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      chk_rd("os_count", 2'd2, 32'd5 - 32'(i));
      chk_irq("os_irq_low", 1'b0);
      tick();
    end
    chk_irq("os_irq_edge7", 1'b1);
    chk_rd("os_count0", 2'd2, 32'd0);
    tick();
    chk_rd("os_ctrl_en_clr", 2'd0, 32'h8);
    repeat (3) tick();
    chk_irq("os_irq_sticky", 1'b1);
    wr(2'd0, 32'h0);
    chk_irq("os_irq_cleared", 1'b0);

    // Auto-reload, PRESET=3: pulses after edges 5 and 10
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int e = 1; e <= 11; e++) begin
      tick();
      chk_irq("ar_irq", (e == 5 || e == 10) ? 1'b1 : 1'b0);
    end
    chk_rd("ar_ctrl_en", 2'd0, 32'hB);
    wr(2'd0, 32'h0);
    repeat (3) tick();
    chk_irq("ar_stopped", 1'b0);

    // PRESET=0 behaves as PRESET=1
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    repeat (2) tick();
    chk_rd("z_count", 2'd2, 32'd0);
    chk_irq("z_irq_e2", 1'b0);
    tick();
    chk_irq("z_irq_e3", 1'b1);
    wr(2'd0, 32'h0);
    chk_irq("z_irq_clr", 1'b0);

    // IM=0: no IRQ; enabling IM by a CTRL write clears PEND
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk_irq("m_irq_masked", 1'b0);
    end
    chk_rd("m_ctrl_en_clr", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    chk_irq("m_irq_after_im", 1'b0);
    tick();
    chk_irq("m_irq_after_im2", 1'b0);
    chk_rd("m_ctrl8", 2'd0, 32'h8);

    // Pause at 40, restart reloads 100, PRESET change only at next LOAD
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h1);
    repeat (2) tick();
    chk_rd("p_count100", 2'd2, 32'd100);
    repeat (59) tick();
    chk_rd("p_count41", 2'd2, 32'd41);
    wr(2'd0, 32'h0);
    chk_rd("p_count40", 2'd2, 32'd40);
    repeat (4) tick();
    chk_rd("p_hold40", 2'd2, 32'd40);
    wr(2'd0, 32'h1);
    tick();
    chk_rd("p_load_pending", 2'd2, 32'd40);
    tick();
    chk_rd("p_reload100", 2'd2, 32'd100);
    repeat (3) tick();
    wr(2'd1, 32'd7);
    chk_rd("p_preset7", 2'd1, 32'd7);
    chk_rd("p_count96", 2'd2, 32'd96);
    tick();
    chk_rd("p_count95", 2'd2, 32'd95);
    wr(2'd0, 32'h0);
    tick();
    wr(2'd0, 32'h1);
    repeat (2) tick();
    chk_rd("p_reload7", 2'd2, 32'd7);

    // Async reset mid-count at COUNT=10
    wr(2'd0, 32'h0);
    wr(2'd1, 32'd12);
    wr(2'd0, 32'h9);
    repeat (4) tick();
    chk_rd("r_count10", 2'd2, 32'd10);
    async_reset("r_mid");
    repeat (5) tick();
    chk_rd("r_idle_count", 2'd2, 32'd0);
    chk_rd("r_idle_ctrl", 2'd0, 32'd0);

    // Async reset while PEND/IRQ high
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    repeat (3) tick();
    chk_irq("r_irq_before", 1'b1);
    async_reset("r_pend");
    repeat (3) tick();
    chk_irq("r_irq_after", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
